// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: head drives the output, skid absorbs one word when
// downstream stalls. in_ready is decoded from registered state only, so there
// is no combinational path from out_ready to in_ready.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] head, head_nxt;
  logic [WIDTH-1:0] skid, skid_nxt;
  logic             accept, pop;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign level     = state;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // State and storage registers; reset outranks everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

  // Next-state and storage update; flush discards everything, including any
  // word offered in the same cycle.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = EMPTY;
      head_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head_nxt  = in_data;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (accept && !pop) begin
            skid_nxt  = in_data;
            state_nxt = FULL;
          end else if (pop && !accept) begin
            state_nxt = EMPTY;
          end else if (accept && pop) begin
            head_nxt  = in_data;
          end
        end
        FULL: begin
          if (pop) begin
            head_nxt  = skid;
            state_nxt = BUSY;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

endmodule
